// File: rtl/score_keeper.sv
// -----------------------------------------------------------------------------
// score_keeper
//   Pong scoreboard sitting between the ball/paddle logic and the VGA video mux.
//   It tracks the raster position from the sync pulses, detects the ball
//   leaving the playfield at the left (column 0) or right (p_LAST_COL) edge,
//   keeps two 0-9 scores, sequences serve-hold / play / game-over, and draws
//   both scores as 3x5 block digits.
//
// Optional feature macro: SCORE_FLASH_EN
//   Defined   : in the game-over state the winning digit blinks (16 frames
//               blank, 16 frames shown) from a 5-bit frame counter.
//   Undefined : both digits are drawn steadily in every state.
//
// Ports
//   i_Clk         pixel clock
//   i_Reset       asynchronous, active-high reset
//   i_HReset      1-cycle pulse at the start of every line
//   i_VReset      1-cycle pulse at the start of every frame
//   i_HBall       ball horizontal video
//   i_VBall       ball vertical video
//   i_Restart     level, restarts the game from game-over at a frame start
//   o_Video       score digit video (registered, ORed into the VGA video)
//   o_Serve_Hold  high while the ball must be frozen / recentred
//   o_Game_Over   high in the game-over state
//   o_Score_L     left player score
//   o_Score_R     right player score
// -----------------------------------------------------------------------------
module score_keeper #(
  parameter int p_SCALE       = 8,
  parameter int p_LEFT_X      = 256,
  parameter int p_RIGHT_X     = 360,
  parameter int p_TOP_Y       = 16,
  parameter int p_LAST_COL    = 639,
  parameter int p_HOLD_FRAMES = 60,
  parameter int p_WIN_SCORE   = 9
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_HReset,
  input  logic       i_VReset,
  input  logic       i_HBall,
  input  logic       i_VBall,
  input  logic       i_Restart,
  output logic       o_Video,
  output logic       o_Serve_Hold,
  output logic       o_Game_Over,
  output logic [3:0] o_Score_L,
  output logic [3:0] o_Score_R
);

  // p_SCALE is a power of two, so font cell coordinates are a plain shift.
  localparam int         SHIFT    = $clog2(p_SCALE);
  localparam logic [9:0] CNT_MAX  = 10'h3FF;
  localparam logic [9:0] LAST_COL = 10'(p_LAST_COL);
  localparam logic [7:0] HOLD_LD  = 8'(p_HOLD_FRAMES);
  localparam logic [3:0] WIN      = 4'(p_WIN_SCORE);

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_PLAY = 2'd1,
    S_OVER = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [9:0] col_q, col_d;
  logic [9:0] line_q, line_d;
  logic [3:0] score_l_q, score_l_d;
  logic [3:0] score_r_q, score_r_d;
  logic [7:0] hold_q, hold_d;
  logic       miss_l_q, miss_l_d;
  logic       miss_r_q, miss_r_d;
  logic       video_q, video_d;
  logic       serve_hold_q, serve_hold_d;
  logic       game_over_q, game_over_d;
  logic       ball_px;
  logic       flash_off;
  logic       blank_l, blank_r;
  logic       hit_l, hit_r;

  // 3x5 glyphs, top row first, leftmost pixel is the MSB of each row.
  // Codes 10-15 are never produced by the scorer and draw nothing.
  function automatic logic [14:0] glyph(input logic [3:0] digit);
    logic [14:0] g;
    case (digit)
      4'd0:    g = 15'b111_101_101_101_111;
      4'd1:    g = 15'b010_110_010_010_111;
      4'd2:    g = 15'b111_001_111_100_111;
      4'd3:    g = 15'b111_001_001_001_111;
      4'd4:    g = 15'b101_101_111_001_001;
      4'd5:    g = 15'b111_100_111_001_111;
      4'd6:    g = 15'b111_100_111_101_111;
      4'd7:    g = 15'b111_001_001_001_001;
      4'd8:    g = 15'b111_101_111_101_111;
      4'd9:    g = 15'b111_101_111_001_111;
      default: g = 15'b000_000_000_000_000;
    endcase
    return g;
  endfunction

  // One digit's pixel at raster position (col, line) for a digit whose
  // first column is x0.
  function automatic logic digit_px(input logic [9:0] col,
                                    input logic [9:0] line,
                                    input int         x0,
                                    input logic [3:0] digit);
    int          dx;
    int          dy;
    int          cx;
    int          cy;
    logic [14:0] g;
    logic        px;
    dx = int'(col) - x0;
    dy = int'(line) - p_TOP_Y;
    px = 1'b0;
    if (dx >= 0 && dx < 3 * p_SCALE && dy >= 0 && dy < 5 * p_SCALE) begin
      cx = dx >> SHIFT;
      cy = dy >> SHIFT;
      g  = glyph(digit);
      px = g[4'(14 - (cy * 3 + cx))];
    end
    return px;
  endfunction

  assign ball_px = i_HBall & i_VBall;

  // Raster counters: saturate instead of wrapping so a missing sync pulse
  // cannot alias a far-right pixel onto column 0.
  always_comb begin
    col_d  = col_q;
    line_d = line_q;
    if (i_HReset) begin
      col_d = '0;
    end else if (col_q != CNT_MAX) begin
      col_d = col_q + 10'd1;
    end
    if (i_VReset) begin
      line_d = '0;
    end else if (i_HReset && line_q != CNT_MAX) begin
      line_d = line_q + 10'd1;
    end
  end

  // Game FSM: every decision happens on the frame-start pulse; between frame
  // starts only the miss flags accumulate.
  always_comb begin
    state_d   = state_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    hold_d    = hold_q;
    miss_l_d  = miss_l_q;
    miss_r_d  = miss_r_q;

    if (i_VReset) begin
      miss_l_d = 1'b0;
      miss_r_d = 1'b0;
      case (state_q)
        S_PLAY: begin
          // Left miss takes priority; at most one point per frame.
          if (miss_l_q) begin
            score_r_d = score_r_q + 4'd1;
            if (score_r_d == WIN) begin
              state_d = S_OVER;
            end else begin
              state_d = S_HOLD;
              hold_d  = HOLD_LD;
            end
          end else if (miss_r_q) begin
            score_l_d = score_l_q + 4'd1;
            if (score_l_d == WIN) begin
              state_d = S_OVER;
            end else begin
              state_d = S_HOLD;
              hold_d  = HOLD_LD;
            end
          end
        end
        S_HOLD: begin
          // A zero count only occurs straight out of reset: the first frame
          // start arms the full serve delay.
          if (hold_q == 8'd1) begin
            state_d = S_PLAY;
            hold_d  = 8'd0;
          end else if (hold_q == 8'd0) begin
            hold_d = HOLD_LD;
          end else begin
            hold_d = hold_q - 8'd1;
          end
        end
        S_OVER: begin
          if (i_Restart) begin
            score_l_d = 4'd0;
            score_r_d = 4'd0;
            state_d   = S_HOLD;
            hold_d    = HOLD_LD;
          end
        end
        default: begin
          state_d = S_HOLD;
          hold_d  = HOLD_LD;
        end
      endcase
    end else if (state_q == S_PLAY && ball_px) begin
      if (col_q == 10'd0) begin
        miss_l_d = 1'b1;
      end
      if (col_q == LAST_COL) begin
        miss_r_d = 1'b1;
      end
    end

    // Status outputs are registered from the next state so they change on
    // the same edge as the scores.
    serve_hold_d = (state_d != S_PLAY);
    game_over_d  = (state_d == S_OVER);
  end

`ifdef SCORE_FLASH_EN
  logic [4:0] frame_q, frame_d;

  always_comb begin
    frame_d = frame_q;
    if (i_VReset) begin
      frame_d = frame_q + 5'd1;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      frame_q <= '0;
    end else begin
      frame_q <= frame_d;
    end
  end

  assign flash_off = frame_q[4];
`else
  assign flash_off = 1'b0;
`endif

  // Only the digit that reached the winning score blinks; the loser stays lit.
  assign blank_l = (state_q == S_OVER) && (score_l_q == WIN) && flash_off;
  assign blank_r = (state_q == S_OVER) && (score_r_q == WIN) && flash_off;

  always_comb begin
    hit_l   = digit_px(col_q, line_q, p_LEFT_X, score_l_q) & ~blank_l;
    hit_r   = digit_px(col_q, line_q, p_RIGHT_X, score_r_q) & ~blank_r;
    video_d = hit_l | hit_r;
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q      <= S_HOLD;
      col_q        <= '0;
      line_q       <= '0;
      score_l_q    <= '0;
      score_r_q    <= '0;
      hold_q       <= '0;
      miss_l_q     <= 1'b0;
      miss_r_q     <= 1'b0;
      video_q      <= 1'b0;
      serve_hold_q <= 1'b1;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      line_q       <= line_d;
      score_l_q    <= score_l_d;
      score_r_q    <= score_r_d;
      hold_q       <= hold_d;
      miss_l_q     <= miss_l_d;
      miss_r_q     <= miss_r_d;
      video_q      <= video_d;
      serve_hold_q <= serve_hold_d;
      game_over_q  <= game_over_d;
    end
  end

  assign o_Video      = video_q;
  assign o_Serve_Hold = serve_hold_q;
  assign o_Game_Over  = game_over_q;
  assign o_Score_L    = score_l_q;
  assign o_Score_R    = score_r_q;

endmodule

// File: tb/tb_score_keeper.sv
// -----------------------------------------------------------------------------
// tb_score_keeper
//   Bench for score_keeper with default parameters. A behavioural model of the
//   scoreboard (frames-remaining countdown, integer scores, division-based
//   font lookup) runs in lockstep with the DUT and every clock is compared.
//   A constant vector table covers the post-reset hold state, and hand-built
//   sequences cover serve timing, misses, game over, restart, rendering and
//   asynchronous reset; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_score_keeper;

  localparam int HOLD = 60;
  localparam int WIN  = 9;
  localparam int LAST = 639;
  localparam int LX   = 256;
  localparam int RX   = 360;
  localparam int TY   = 16;
  localparam int SC   = 8;
  localparam int MP   = 0;  // play
  localparam int MH   = 1;  // serve hold
  localparam int MO   = 2;  // game over

  logic       clk = 1'b0;
  logic       rst;
  logic       hr, vr, hb, vb, restart;
  logic       o_Video, o_Serve_Hold, o_Game_Over;
  logic [3:0] o_Score_L, o_Score_R;

  always #5 clk = ~clk;

  score_keeper dut (
    .i_Clk        (clk),
    .i_Reset      (rst),
    .i_HReset     (hr),
    .i_VReset     (vr),
    .i_HBall      (hb),
    .i_VBall      (vb),
    .i_Restart    (restart),
    .o_Video      (o_Video),
    .o_Serve_Hold (o_Serve_Hold),
    .o_Game_Over  (o_Game_Over),
    .o_Score_L    (o_Score_L),
    .o_Score_R    (o_Score_R)
  );

  typedef struct {
    bit h, v, bh, bv, rs;
    bit e_sh, e_go, e_vid;
    int e_sl, e_sr;
  } vec_t;

  vec_t        tbl[8];
  int          n_vec = 0;
  int          n_bad = 0;
  logic [14:0] font[10];

  // Reference model state
  int m_col, m_line, m_sl, m_sr, m_state, m_left, m_frame;
  bit m_ml, m_mr, m_video;

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  function automatic bit m_render(input int col, input int line);
    bit          v;
    int          x0;
    int          sc;
    bit          blank;
    logic [14:0] g;
    v = 1'b0;
    for (int s = 0; s < 2; s++) begin
      x0    = (s == 0) ? LX : RX;
      sc    = (s == 0) ? m_sl : m_sr;
      blank = 1'b0;
`ifdef SCORE_FLASH_EN
      if (m_state == MO && sc == WIN && ((m_frame / 16) % 2) == 1) blank = 1'b1;
`endif
      if (!blank && sc < 10 && col >= x0 && col < x0 + 3 * SC &&
          line >= TY && line < TY + 5 * SC) begin
        g = font[sc];
        if (g[4'(14 - (((line - TY) / SC) * 3 + (col - x0) / SC))]) v = 1'b1;
      end
    end
    return v;
  endfunction

  task automatic model_reset();
    m_col = 0; m_line = 0; m_sl = 0; m_sr = 0;
    m_state = MH; m_left = HOLD + 1; m_frame = 0;
    m_ml = 1'b0; m_mr = 1'b0; m_video = 1'b0;
  endtask

  // One clock of the scoreboard rules, applied at the active edge.
  task automatic model_step(input bit h, input bit v, input bit bh, input bit bv, input bit rs);
    m_video = m_render(m_col, m_line);
    if (v) begin
      if (m_state == MP) begin
        if (m_ml) begin
          m_sr++;
          if (m_sr == WIN) m_state = MO; else begin m_state = MH; m_left = HOLD; end
        end else if (m_mr) begin
          m_sl++;
          if (m_sl == WIN) m_state = MO; else begin m_state = MH; m_left = HOLD; end
        end
      end else if (m_state == MH) begin
        m_left--;
        if (m_left == 0) m_state = MP;
      end else if (rs) begin
        m_sl = 0; m_sr = 0; m_state = MH; m_left = HOLD;
      end
      m_ml = 1'b0; m_mr = 1'b0;
      m_frame = (m_frame + 1) % 32;
    end else if (m_state == MP && bh && bv) begin
      if (m_col == 0) m_ml = 1'b1;
      if (m_col == LAST) m_mr = 1'b1;
    end
    if (h) m_col = 0; else if (m_col < 1023) m_col++;
    if (v) m_line = 0; else if (h && m_line < 1023) m_line++;
  endtask

  task automatic cyc(input bit h, input bit v, input bit bh, input bit bv, input bit rs);
    hr = h; vr = v; hb = bh; vb = bv; restart = rs;
    @(posedge clk);
    model_step(h, v, bh, bv, rs);
    #1;
    chk("cycle", {5'd0, o_Video, o_Serve_Hold, o_Game_Over, o_Score_L, o_Score_R},
        {5'd0, m_video, m_state != MP, m_state == MO, 4'(m_sl), 4'(m_sr)});
  endtask

  task automatic vsync(input bit rs);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, rs);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // New line, then len pixels; ball pixel at columns t0 and t1.
  task automatic ball_line(input int len, input int t0, input int t1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < len; c++) cyc(1'b0, 1'b0, c == t0 || c == t1, c == t0 || c == t1, 1'b0);
  endtask

  task automatic do_reset();
    hr = 0; vr = 0; hb = 0; vb = 0; restart = 0;
    #2 rst = 1'b1;
    #1;
    chk("async_reset", {5'd0, o_Video, o_Serve_Hold, o_Game_Over, o_Score_L, o_Score_R},
        {5'd0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0});
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One frame drawn far enough to cover both digits, with spot checks.
  task automatic render_frame();
    vsync(1'b0);
    repeat (TY - 1) begin cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); idle(1); end
    for (int l = TY; l <= TY + 5 * SC; l++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int c = 0; c < RX + 3 * SC + 2; c++) begin
        idle(1);
        if (l == TY && c == LX - 1)     chk("px_255_16_off", 16'(o_Video), 16'd0);
        if (l == TY && c == LX)         chk("px_256_16_on", 16'(o_Video), 16'd1);
        if (l == 32 && c == 264)        chk("px_264_32_off", 16'(o_Video), 16'd0);
        if (l == TY && c == RX)         chk("px_360_16_on", 16'(o_Video), 16'd1);
        if (l == TY + 5 * SC && c == LX) chk("px_below_digit", 16'(o_Video), 16'd0);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    int nl;
    int r;

    font[0] = 15'b111_101_101_101_111;
    font[1] = 15'b010_110_010_010_111;
    font[2] = 15'b111_001_111_100_111;
    font[3] = 15'b111_001_001_001_111;
    font[4] = 15'b101_101_111_001_001;
    font[5] = 15'b111_100_111_001_111;
    font[6] = 15'b111_100_111_101_111;
    font[7] = 15'b111_001_001_001_001;
    font[8] = 15'b111_101_111_101_111;
    font[9] = 15'b111_101_111_001_111;

    // Hold state straight after reset: misses and restart are ignored.
    tbl[0] = '{1, 1, 0, 0, 0, 1, 0, 0, 0, 0};
    tbl[1] = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    tbl[2] = '{0, 0, 1, 1, 0, 1, 0, 0, 0, 0};
    tbl[3] = '{1, 1, 0, 0, 1, 1, 0, 0, 0, 0};
    tbl[4] = '{0, 0, 1, 1, 0, 1, 0, 0, 0, 0};
    tbl[5] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0};
    tbl[6] = '{1, 1, 0, 0, 0, 1, 0, 0, 0, 0};
    tbl[7] = '{0, 0, 1, 0, 0, 1, 0, 0, 0, 0};

    rst = 1'b1; hr = 0; vr = 0; hb = 0; vb = 0; restart = 0;
    model_reset();
    #1;
    chk("reset_state", {5'd0, o_Video, o_Serve_Hold, o_Game_Over, o_Score_L, o_Score_R},
        {5'd0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0});
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      cyc(tbl[i].h, tbl[i].v, tbl[i].bh, tbl[i].bv, tbl[i].rs);
      chk("table", {5'd0, o_Video, o_Serve_Hold, o_Game_Over, o_Score_L, o_Score_R},
          {5'd0, tbl[i].e_vid, tbl[i].e_sh, tbl[i].e_go, 4'(tbl[i].e_sl), 4'(tbl[i].e_sr)});
    end

    // First serve waits 60 frames after reset.
    do_reset();
    for (int f = 1; f <= 61; f++) begin
      vsync(1'b0);
      chk("serve_hold_after_reset", 16'(o_Serve_Hold), (f <= 60) ? 16'd1 : 16'd0);
      idle(2);
    end

    // Miss at column 0 on line 200.
    vsync(1'b0);
    repeat (199) begin cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); idle(1); end
    ball_line(5, 0, 0);
    vsync(1'b0);
    chk("miss_left_score_r", 16'(o_Score_R), 16'd1);
    chk("miss_left_score_l", 16'(o_Score_L), 16'd0);
    chk("miss_left_hold", 16'(o_Serve_Hold), 16'd1);
    for (int f = 1; f <= 60; f++) begin
      vsync(1'b0);
      chk("hold_after_point", 16'(o_Serve_Hold), (f < 60) ? 16'd1 : 16'd0);
      idle(2);
    end

    // Both edges in one frame: only the left miss scores.
    vsync(1'b0);
    ball_line(641, 0, LAST);
    vsync(1'b0);
    chk("both_edges_score_r", 16'(o_Score_R), 16'd2);
    chk("both_edges_score_l", 16'(o_Score_L), 16'd0);

    // Asynchronous reset mid-line while holding, then "0 0" is drawn.
    repeat (5) begin vsync(1'b0); idle(1); end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(100);
    do_reset();
    render_frame();
    repeat (59) begin vsync(1'b0); idle(1); end
    chk("still_hold_frame_60", 16'(o_Serve_Hold), 16'd1);
    vsync(1'b0);
    chk("play_frame_61", 16'(o_Serve_Hold), 16'd0);

    // Left player scores to the winning total via right-edge misses.
    for (int k = 1; k <= 9; k++) begin
      vsync(1'b0);
      ball_line(641, LAST, LAST);
      vsync(1'b0);
      chk("score_l_step", 16'(o_Score_L), 16'(k));
      chk("game_over_step", 16'(o_Game_Over), (k == 9) ? 16'd1 : 16'd0);
      chk("serve_hold_step", 16'(o_Serve_Hold), 16'd1);
      if (k < 9) begin
        repeat (60) begin vsync(1'b0); idle(1); end
        chk("play_again", 16'(o_Serve_Hold), 16'd0);
      end
      if (k == 3) render_frame();
    end

    // Game over: misses ignored, restart low has no effect, restart high resets.
    ball_line(5, 0, 0);
    vsync(1'b0);
    chk("over_miss_ignored", 16'(o_Score_R), 16'd0);
    chk("over_scores_frozen", 16'(o_Score_L), 16'd9);
    vsync(1'b0);
    chk("over_stays", 16'(o_Game_Over), 16'd1);
    vsync(1'b1);
    chk("restart_score_l", 16'(o_Score_L), 16'd0);
    chk("restart_game_over", 16'(o_Game_Over), 16'd0);
    chk("restart_hold", 16'(o_Serve_Hold), 16'd1);
    for (int f = 1; f <= 60; f++) begin
      vsync(1'b0);
      chk("hold_after_restart", 16'(o_Serve_Hold), (f < 60) ? 16'd1 : 16'd0);
      idle(1);
    end

    // Restart during play is ignored; the miss still scores.
    vsync(1'b0);
    ball_line(5, 0, 0);
    vsync(1'b1);
    chk("restart_in_play_ignored", 16'(o_Score_R), 16'd1);

    // Randomized frames against the model.
    do_reset();
    for (int fr = 0; fr < 120; fr++) begin
      vsync(($urandom % 3) == 0);
      nl = 1 + int'($urandom_range(2, 0));
      for (int l = 0; l < nl; l++) begin
        r = int'($urandom_range(19, 0));
        if (r == 0) len = 1100;
        else if (r < 3) len = 636 + int'($urandom_range(7, 0));
        else len = 1 + int'($urandom_range(14, 0));
        cyc(1'b1, 1'b0, ($urandom % 2) == 0, ($urandom % 2) == 0, 1'b0);
        for (int c = 0; c < len; c++)
          cyc(1'b0, 1'b0, ($urandom % 3) == 0, ($urandom % 2) == 0, ($urandom % 2) == 0);
      end
      if (($urandom % 120) == 0) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
